seq_gen_ctrl: RTL and testbench
===============================

Name: seq_gen_ctrl

Overview:
Controller for the serial sequence-generator datapath (bit-index counter plus W:1 bit-select mux).
- Latches a pattern word on a start command.
- Steps the bit index LSB- or MSB-first and emits one bit per clock with a valid qualifier.
- Repeats the frame a programmable number of times, with programmable idle gaps between frames.
- Reports busy/done and supports synchronous abort.

It sits between the pattern source (register/host logic) and the serial sink.

Parameters:
W, 8, pattern width in bits (≥2).
RPT_W, 4, width of repeat-count input.
GAP, 2, idle cycles inserted between consecutive frames (0 allowed).

Ports:
clk  input  1  clock, rising-edge active.
clrn  input  1  reset, asynchronous, active-low.
start  input  1  request a new sequence; honoured only in IDLE.
abort  input  1  synchronous abort; highest priority after reset.
din  input  W  pattern word; latched on accepted start.
rpt  input  RPT_W  extra repeats; total frames = rpt+1; latched on accepted start.
msb_first  input  1  1 = bit W-1 first, 0 = bit 0 first; latched on accepted start.
ds  output  1  serial data bit; 0 whenever ds_valid=0.
ds_valid  output  1  ds carries a pattern bit this cycle.
bit_idx  output  clog2(W)  index of bit currently presented.
busy  output  1  state ≠ IDLE.
done  output  1  one-cycle pulse after the final bit of the final frame.

Behaviour:
Reset (clrn=0, async):
- state=IDLE; pattern, frame counter, gap counter = 0.
- ds=0, ds_valid=0, bit_idx=0, busy=0, done=0.
- Reset mid-sequence truncates output immediately and produces no done.

States: IDLE, SHIFT, GAP.

IDLE:
- start=1 and abort=0 at a clock edge: latch din, rpt, msb_first; bit_idx = (msb_first ? W-1 : 0); go to SHIFT.
- The first bit is valid in the cycle immediately after the accepting edge (latency 1).

SHIFT:
- ds_valid=1; ds = pattern[bit_idx] (combinational select from latched pattern).
- Each cycle bit_idx steps +1 (LSB-first) or -1 (MSB-first).
- Last bit of a frame (idx W-1 or 0 respectively):
  - frames remaining > 0: decrement frame counter, reload bit_idx, go to GAP (or directly to SHIFT when GAP=0, giving contiguous frames).
  - otherwise: go to IDLE and assert done in the next cycle.

GAP:
- ds_valid=0, ds=0, bit_idx holds its reload value.
- Counts GAP cycles, then returns to SHIFT.

done:
- Registered; high exactly one cycle, coincident with the first IDLE cycle.
- A start in that cycle is accepted.

abort=1 at any edge:
- state→IDLE; ds_valid=0 and busy=0 next cycle; no done pulse.
- abort and start in the same cycle: abort wins, start ignored.

start while busy: ignored, with no queuing.

din/rpt/msb_first changes after acceptance do not affect the running sequence.

Counters:
- The frame counter is RPT_W bits, so no wrap occurs; rpt=all-ones gives 2^RPT_W frames.
- The bit index wraps only via explicit reload, never by overflow.

Total busy cycles = (rpt+1)·W + rpt·GAP.

Decomposition:
- Shared package seq_gen_pkg holds:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2);
  - the clog2 helper function;
  - default W/GAP constants shared with the datapath.
- One natural sub-module: seq_bit_sel, the W:1 bit-select mux (pattern, bit_idx → ds, gated by ds_valid).
- The FSM and counters stay in seq_gen_ctrl.

Test Plan:
1. Hold clrn=0, then release. Expect ds=0, ds_valid=0, busy=0, done=0, bit_idx=0, with all outputs stable until start.
2. W=8, din=8'b1011_0010, rpt=0, msb_first=0, start pulse. Starting one cycle later, expect ds=0,1,0,0,1,1,0,1 with ds_valid=1 for 8 cycles and busy=1 for those 8 cycles, then done=1 for one cycle.
3. Same din with msb_first=1. Expect ds=1,0,1,1,0,0,1,0 and bit_idx=7..0.
4. din=8'hA5, rpt=2, GAP=2. Expect three 8-bit frames, each separated by 2 cycles of ds_valid=0, busy=28 cycles, and exactly one done pulse. Repeat with GAP=0 and rpt=1: expect 16 contiguous valid cycles.
5. Assert abort during bit 3 of frame 1 (rpt=3). Expect ds_valid=0 and busy=0 next cycle and no done. A new start with din=8'hFF then yields eight 1s.
6. During an active frame: pulse start, change din to 8'h00, and apply start+abort together in IDLE. Expect the running output unchanged, no restart, and that the start coincident with abort is not accepted (busy stays 0).

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial sequence generator: state encoding,
// default sizing constants and a constant-foldable clog2 helper.
package seq_gen_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_RPT_W = 4;
    localparam int DEF_GAP   = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Never returns less than 1 so that every derived vector has a legal width.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_bit_sel.sv
// W:1 bit-select mux feeding the serial sink; output forced low when not valid.
module seq_bit_sel
    import seq_gen_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int IW = clog2(DEF_W)
) (
    input  logic [W-1:0]  pattern,
    input  logic [IW-1:0] bit_idx,
    input  logic          en,
    output logic          ds
);

    assign ds = en & pattern[bit_idx];

endmodule

// File: rtl/seq_gen_ctrl.sv
// Sequence-generator controller: latches a pattern on start, shifts it out
// LSB- or MSB-first, repeats it rpt+1 times with GAP idle cycles between frames.
module seq_gen_ctrl
    import seq_gen_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int RPT_W = DEF_RPT_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                start,
    input  logic                abort,
    input  logic [W-1:0]        din,
    input  logic [RPT_W-1:0]    rpt,
    input  logic                msb_first,
    output logic                ds,
    output logic                ds_valid,
    output logic [clog2(W)-1:0] bit_idx,
    output logic                busy,
    output logic                done
);

    localparam int IW = clog2(W);
    localparam int GW = clog2(GAP + 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(W - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t           state_q, state_d;
    logic [W-1:0]     pattern_q, pattern_d;
    logic [RPT_W-1:0] frame_q, frame_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             msb_q, msb_d;
    logic             done_q, done_d;
    logic [IW-1:0]    first_idx;
    logic [IW-1:0]    last_idx;

    assign first_idx = msb_q ? IDX_MAX : '0;
    assign last_idx  = msb_q ? '0 : IDX_MAX;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            frame_q   <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            msb_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            frame_q   <= frame_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            msb_q     <= msb_d;
            done_q    <= done_d;
        end
    end

    // Abort overrides everything, including a start arriving in the same cycle.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        frame_d   = frame_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        msb_d     = msb_q;
        done_d    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pattern_d = din;
                        frame_d   = rpt;
                        msb_d     = msb_first;
                        idx_d     = msb_first ? IDX_MAX : '0;
                        state_d   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (idx_q == last_idx) begin
                        if (frame_q != '0) begin
                            frame_d = frame_q - 1'b1;
                            idx_d   = first_idx;
                            gap_d   = '0;
                            state_d = (GAP > 0) ? S_GAP : S_SHIFT;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = msb_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_SHIFT;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign ds_valid = (state_q == S_SHIFT);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign bit_idx  = idx_q;

    seq_bit_sel #(
        .W  (W),
        .IW (IW)
    ) u_bit_sel (
        .pattern (pattern_q),
        .bit_idx (idx_q),
        .en      (ds_valid),
        .ds      (ds)
    );

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Scoreboard bench for seq_gen_ctrl: expected per-cycle outputs are queued when
// a start is issued and compared on each falling edge.
module tb_seq_gen_ctrl;

    localparam int W     = 8;
    localparam int RPT_W = 4;

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             start_a = 1'b0;
    logic             start_b = 1'b0;
    logic             abort = 1'b0;
    logic             msb_first = 1'b0;
    logic [W-1:0]     din = '0;
    logic [RPT_W-1:0] rpt = '0;

    logic       ds_a, ds_valid_a, busy_a, done_a;
    logic [2:0] bit_idx_a;
    logic       ds_b, ds_valid_b, busy_b, done_b;
    logic [2:0] bit_idx_b;

    always #5 clk = ~clk;

    seq_gen_ctrl #(.W(W), .RPT_W(RPT_W), .GAP(2)) dut_gap2 (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start_a),
        .abort     (abort),
        .din       (din),
        .rpt       (rpt),
        .msb_first (msb_first),
        .ds        (ds_a),
        .ds_valid  (ds_valid_a),
        .bit_idx   (bit_idx_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    seq_gen_ctrl #(.W(W), .RPT_W(RPT_W), .GAP(0)) dut_gap0 (
        .clk       (clk),
        .clrn      (clrn),
        .start     (start_b),
        .abort     (abort),
        .din       (din),
        .rpt       (rpt),
        .msb_first (msb_first),
        .ds        (ds_b),
        .ds_valid  (ds_valid_b),
        .bit_idx   (bit_idx_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic       ds;
        logic [2:0] idx;
        logic       done;
    } out_t;

    typedef struct {
        out_t  v;
        bit    chk_idx;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    bit   use_b = 1'b0;

    task automatic push(input string tag, input logic busy, input logic valid,
                        input logic ds, input logic [2:0] idx, input logic done,
                        input bit chk);
        exp_t e;
        e.v.busy  = busy;
        e.v.valid = valid;
        e.v.ds    = ds;
        e.v.idx   = idx;
        e.v.done  = done;
        e.chk_idx = chk;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic push_idle(input string tag, input int n, input bit chk_zero);
        for (int i = 0; i < n; i++) push(tag, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, chk_zero);
    endtask

    // Drives a start for the next rising edge and queues the whole expected stream.
    task automatic apply_stimulus(input string tag, input logic [W-1:0] d,
                                  input logic [RPT_W-1:0] r, input logic m,
                                  input bit on_b, input int gap);
        logic [2:0] idx;
        logic [2:0] first;
        din       = d;
        rpt       = r;
        msb_first = m;
        if (on_b) start_b = 1'b1;
        else      start_a = 1'b1;
        first = m ? 3'd7 : 3'd0;
        for (int f = 0; f <= int'(r); f++) begin
            for (int k = 0; k < W; k++) begin
                idx = m ? 3'(W - 1 - k) : 3'(k);
                push(tag, 1'b1, 1'b1, d[idx], idx, 1'b0, 1'b1);
            end
            if (f < int'(r))
                for (int g = 0; g < gap; g++) push(tag, 1'b1, 1'b0, 1'b0, first, 1'b0, 1'b1);
        end
        push(tag, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic check_output();
        exp_t e;
        out_t obs;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        abort   = 1'b0;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL sb_empty: observed no queued expectation, required one");
            return;
        end
        e = sb.pop_front();
        if (use_b) begin
            obs.busy = busy_b; obs.valid = ds_valid_b; obs.ds = ds_b;
            obs.idx = bit_idx_b; obs.done = done_b;
        end else begin
            obs.busy = busy_a; obs.valid = ds_valid_a; obs.ds = ds_a;
            obs.idx = bit_idx_a; obs.done = done_a;
        end
        if (!e.chk_idx) obs.idx = e.v.idx;
        assert (obs === e.v) else begin
            tests_failed++;
            $display("[TB] FAIL %s: busy/valid/ds/idx/done observed %b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                     e.tag, obs.busy, obs.valid, obs.ds, obs.idx, obs.done,
                     e.v.busy, e.v.valid, e.v.ds, e.v.idx, e.v.done);
            $error("[TB] %s", e.tag);
        end
    endtask

    task automatic drain_until(input int k);
        while (sb.size() > k) check_output();
    endtask

    initial begin
        // Reset held, then released: idle outputs with bit_idx at zero.
        push_idle("reset_hold", 2, 1'b1);
        drain_until(0);
        clrn = 1'b1;
        push_idle("reset_idle", 3, 1'b1);
        drain_until(0);

        // LSB-first frame, then MSB-first accepted in the done cycle.
        apply_stimulus("lsb_b2", 8'b1011_0010, 4'd0, 1'b0, 1'b0, 2);
        drain_until(1);
        check_output();
        apply_stimulus("msb_b2", 8'b1011_0010, 4'd0, 1'b1, 1'b0, 2);
        drain_until(0);
        push_idle("post_msb", 2, 1'b0);
        drain_until(0);

        // Three frames separated by two-cycle gaps.
        apply_stimulus("rpt2_gap2", 8'hA5, 4'd2, 1'b0, 1'b0, 2);
        drain_until(0);
        push_idle("post_rpt2", 1, 1'b0);
        drain_until(0);

        // Contiguous frames on the GAP=0 instance.
        use_b = 1'b1;
        apply_stimulus("rpt1_gap0", 8'hA5, 4'd1, 1'b0, 1'b1, 0);
        drain_until(0);
        push_idle("post_gap0", 1, 1'b0);
        drain_until(0);
        use_b = 1'b0;

        // Abort while bit 3 of the first frame is presented.
        apply_stimulus("abort_run", 8'h3C, 4'd3, 1'b0, 1'b0, 2);
        repeat (4) check_output();
        abort = 1'b1;
        sb.delete();
        push_idle("after_abort", 3, 1'b0);
        drain_until(0);
        apply_stimulus("ones", 8'hFF, 4'd0, 1'b0, 1'b0, 2);
        drain_until(0);
        push_idle("post_ones", 1, 1'b0);
        drain_until(0);

        // Start and din change mid-frame are ignored.
        apply_stimulus("busy_start", 8'b1011_0010, 4'd0, 1'b0, 1'b0, 2);
        repeat (2) check_output();
        start_a = 1'b1;
        din     = 8'h00;
        drain_until(0);
        push_idle("no_restart", 2, 1'b0);
        drain_until(0);

        // Start coincident with abort in IDLE is not accepted.
        start_a = 1'b1;
        abort   = 1'b1;
        din     = 8'hFF;
        push_idle("start_abort", 3, 1'b0);
        drain_until(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
